tdc_measure_controller: RTL and testbench
=========================================

# tdc_measure_controller

- Sequences one time-interval measurement of the TDC front end.
- Gates the quadrature-phase clock generator on and lets it settle. Then it arms on a start event, counts coarse cycles until a stop event, and latches the fine phase code.
- Presents the result on a valid/ready interface to the DAQ readout logic.
- Sits between the event synchronizers and the quadrature fine-time sampler on one side, and the measurement FIFO on the other.

## Interface
Parameters:
- BIT_COUNT, 32, coarse counter and result width
- WARMUP_CYCLES, 8, settle time after clock gate enable, in cycles (≥1)
- TIMEOUT_CYCLES, 1000, coarse count at which a measurement is abandoned (1 ≤ value ≤ 2^BIT_COUNT−1)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- enable  in  1  level; TDC measurement allowed
- startPulse  in  1  single-cycle start event, already synchronized to clk
- stopPulse  in  1  single-cycle stop event, already synchronized to clk
- fineCode  in  4  fine phase snapshot from the quadrature sampler, valid in the cycle stopPulse is high
- clkGateEn  out  1  enables the quadrature clock generator
- busy  out  1  high in WARMUP, ARMED, COUNT and HOLD
- measValid  out  1  result available
- measReady  in  1  consumer accepts the result
- coarseCount  out  BIT_COUNT  coarse cycle count
- fineOut  out  4  latched fine code
- timeout  out  1  result is a timeout, not a real stop

## Operation
States:
- IDLE
- WARMUP
- ARMED
- COUNT
- HOLD

Transitions:
- IDLE: enable=1 → WARMUP. clkGateEn goes high and the counter clears.
- WARMUP: the counter increments each cycle. After WARMUP_CYCLES cycles → ARMED and the counter clears.
- ARMED:
  - startPulse=1 → COUNT, counter=0.
  - startPulse=1 and stopPulse=1 in the same cycle → HOLD with coarseCount=0, fineOut=fineCode, timeout=0.
  - stopPulse alone is ignored.
- COUNT: the counter increments each cycle.
  - stopPulse=1 → HOLD. coarseCount takes the current counter value, fineOut=fineCode, timeout=0.
  - Counter reaches TIMEOUT_CYCLES with no stop → HOLD. coarseCount=TIMEOUT_CYCLES, fineOut=0, timeout=1.
  - If stop and timeout occur in the same cycle, stop wins.
  - startPulse is ignored.
- HOLD: measValid=1; coarseCount, fineOut and timeout stay stable.
  - On an edge with measReady=1: go to ARMED if enable=1, else IDLE.
  - Start/stop pulses are ignored (no queuing).
- enable=0 in WARMUP, ARMED or COUNT → IDLE next cycle. No result is produced and clkGateEn drops.
  - In HOLD, enable=0 does not abort. The pending result must be accepted first, then the block goes to IDLE.
- clkGateEn = busy. Both are high in every state except IDLE.
- Counter arithmetic is unsigned BIT_COUNT bits. It never wraps: TIMEOUT_CYCLES bounds it.

## Timing
- Reset values:
  - state IDLE
  - clkGateEn=0, busy=0, measValid=0, timeout=0
  - coarseCount=0, fineOut=0
  - internal counter 0
- A reset asserted in any state, including mid-measurement or with a result pending, returns every output to these values on the next edge. The pending result is discarded.
- enable to clkGateEn: 1 cycle. The first cycle a start is accepted is WARMUP_CYCLES+1 cycles after enable is first sampled high.
- Coarse count: a start sampled at edge S and a stop sampled at edge S+N give coarseCount=N.
- Result latency: measValid rises on the edge that samples the stop, i.e. it is visible the cycle after stopPulse. Timeout is reported on the edge where the counter equals TIMEOUT_CYCLES.
- Handshake:
  - Transfer happens on an edge with measValid & measReady.
  - measValid falls on that edge.
  - measReady while measValid=0 has no effect.
- Back-to-back measurements: after the handshake edge the block is in ARMED. A start in the very next cycle is accepted, so the dead time is 1 cycle.

## Test plan
- Nominal measurement: enable, WARMUP_CYCLES=8, start at cycle 20, stop at cycle 57 with fineCode=4'hA, measReady=1 → coarseCount=37, fineOut=4'hA, timeout=0, measValid for 1 cycle.
- Timeout: TIMEOUT_CYCLES=50, start with no stop → coarseCount=50, fineOut=0, timeout=1, then return to ARMED after ready.
- Same-cycle events:
  - Start and stop in one cycle → coarseCount=0, fineOut taken from fineCode.
  - Stop in the same cycle the counter hits TIMEOUT_CYCLES → timeout=0.
  - Stop in ARMED without start → no result.
- Backpressure: measReady=0 for 10 cycles while extra start/stop pulses arrive → result stable and unchanged; after ready, ARMED with no spurious second result.
- Abort and reset:
  - enable dropped mid-COUNT → IDLE, clkGateEn=0 next cycle, no measValid.
  - reset asserted during HOLD → all outputs return to reset values on the next edge.
  - enable re-asserted → full WARMUP is repeated before a start is accepted.

Source files
------------

// File: rtl/tdc_measure_controller.sv
// tdc_measure_controller
// Sequences one TDC time-interval measurement: gates the quadrature clock
// generator on, waits for it to settle, arms on a start event, counts coarse
// cycles until a stop event (or a timeout) and holds the result on a
// valid/ready interface until the readout logic accepts it.
module tdc_measure_controller #(
   parameter int BIT_COUNT      = 32,
   parameter int WARMUP_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 startPulse,
   input  logic                 stopPulse,
   input  logic [3:0]           fineCode,
   output logic                 clkGateEn,
   output logic                 busy,
   output logic                 measValid,
   input  logic                 measReady,
   output logic [BIT_COUNT-1:0] coarseCount,
   output logic [3:0]           fineOut,
   output logic                 timeout
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WARMUP = 3'd1,
      S_ARMED  = 3'd2,
      S_COUNT  = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   // Counter value seen in the last warm-up cycle, and the timeout limit.
   localparam logic [BIT_COUNT-1:0] WARMUP_LAST = BIT_COUNT'(WARMUP_CYCLES - 1);
   localparam logic [BIT_COUNT-1:0] TIMEOUT_VAL = BIT_COUNT'(TIMEOUT_CYCLES);
   localparam logic [BIT_COUNT-1:0] CNT_ONE     = BIT_COUNT'(1);

   state_t               state_q, state_d;
   logic [BIT_COUNT-1:0] cnt_q, cnt_d;
   logic [BIT_COUNT-1:0] coarse_q, coarse_d;
   logic [3:0]           fine_q, fine_d;
   logic                 timeout_q, timeout_d;
   logic [BIT_COUNT-1:0] cnt_inc;

   // The counter holds (cycles since start) - 1 while counting, so the
   // incremented value is the interval ending at the current edge. It never
   // exceeds TIMEOUT_CYCLES, so the increment cannot wrap.
   assign cnt_inc = cnt_q + CNT_ONE;

   // Next-state, counter and result-register logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      coarse_d  = coarse_q;
      fine_d    = fine_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_WARMUP;
               cnt_d   = '0;
            end
         end
         S_WARMUP: begin
            if (!enable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == WARMUP_LAST) begin
               state_d = S_ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_ARMED: begin
            // A lone stop is ignored; start and stop together is a zero interval.
            if (!enable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (startPulse) begin
               cnt_d = '0;
               if (stopPulse) begin
                  state_d   = S_HOLD;
                  coarse_d  = '0;
                  fine_d    = fineCode;
                  timeout_d = 1'b0;
               end else begin
                  state_d = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            // Abort beats stop; stop beats timeout.
            if (!enable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
               if (stopPulse) begin
                  state_d   = S_HOLD;
                  coarse_d  = cnt_inc;
                  fine_d    = fineCode;
                  timeout_d = 1'b0;
               end else if (cnt_inc == TIMEOUT_VAL) begin
                  state_d   = S_HOLD;
                  coarse_d  = TIMEOUT_VAL;
                  fine_d    = 4'h0;
                  timeout_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            // Result is held until accepted; enable only selects where to go next.
            if (measReady) begin
               cnt_d   = '0;
               state_d = enable ? S_ARMED : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         coarse_q  <= '0;
         fine_q    <= 4'h0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         coarse_q  <= coarse_d;
         fine_q    <= fine_d;
         timeout_q <= timeout_d;
      end
   end

   // Status outputs decode directly from the registered state.
   assign busy        = (state_q != S_IDLE);
   assign clkGateEn   = busy;
   assign measValid   = (state_q == S_HOLD);
   assign coarseCount = coarse_q;
   assign fineOut     = fine_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_tdc_measure_controller.sv
// Testbench for tdc_measure_controller: table of directed per-step vectors
// plus a hand-written warm-up length sequence.
module tb_tdc_measure_controller;

   localparam int BW = 32;
   localparam int WU = 8;
   localparam int TO = 50;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          startPulse = 1'b0;
   logic          stopPulse = 1'b0;
   logic [3:0]    fineCode = 4'h0;
   logic          measReady = 1'b0;
   logic          clkGateEn;
   logic          busy;
   logic          measValid;
   logic [BW-1:0] coarseCount;
   logic [3:0]    fineOut;
   logic          timeout;

   int n_checks = 0;
   int n_pass   = 0;

   tdc_measure_controller #(
      .BIT_COUNT      (BW),
      .WARMUP_CYCLES  (WU),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .startPulse  (startPulse),
      .stopPulse   (stopPulse),
      .fineCode    (fineCode),
      .clkGateEn   (clkGateEn),
      .busy        (busy),
      .measValid   (measValid),
      .measReady   (measReady),
      .coarseCount (coarseCount),
      .fineOut     (fineOut),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          rep;
      logic        rst;
      logic        en;
      logic        st;
      logic        sp;
      logic [3:0]  fc;
      logic        rdy;
      logic        eb;
      logic        ev;
      logic [31:0] ec;
      logic [3:0]  ef;
      logic        et;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int rep, input logic rst, input logic en, input logic st,
                      input logic sp, input logic [3:0] fc, input logic rdy,
                      input logic eb, input logic ev, input logic [31:0] ec,
                      input logic [3:0] ef, input logic et, input string name);
      vec_t v;
      v.rep = rep; v.rst = rst; v.en = en; v.st = st; v.sp = sp; v.fc = fc; v.rdy = rdy;
      v.eb = eb; v.ev = ev; v.ec = ec; v.ef = ef; v.et = et; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      bit got;

      //   rep rst en st sp fc    rdy  busy valid coarse fine  to  name
      add(2,  1, 0, 0, 0, 4'h0, 0,   0,   0,    0,     4'h0, 0, "reset");
      add(1,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "enable_gate");
      add(1,  0, 1, 1, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "start_in_warmup");
      add(6,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "warmup");
      add(1,  0, 1, 1, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "start_last_warmup");
      add(1,  0, 1, 0, 1, 4'h0, 0,   1,   0,    0,     4'h0, 0, "stop_alone_armed");
      add(1,  0, 1, 1, 1, 4'h5, 0,   1,   1,    0,     4'h5, 0, "start_stop_same");
      add(1,  0, 1, 0, 0, 4'h0, 1,   1,   0,    0,     4'h0, 0, "accept_zero");
      add(1,  0, 1, 1, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "b2b_start");
      add(36, 0, 1, 0, 0, 4'h0, 1,   1,   0,    0,     4'h0, 0, "counting");
      add(1,  0, 1, 0, 1, 4'hA, 1,   1,   1,    37,    4'hA, 0, "nominal_37");
      add(1,  0, 1, 0, 0, 4'h0, 1,   1,   0,    0,     4'h0, 0, "accept_nominal");
      add(1,  0, 1, 1, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "to_start");
      add(48, 0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "to_count");
      add(1,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "to_minus1");
      add(1,  0, 1, 0, 0, 4'h7, 0,   1,   1,    50,    4'h0, 1, "timeout_50");
      add(1,  0, 1, 0, 0, 4'h0, 1,   1,   0,    0,     4'h0, 0, "accept_timeout");
      add(1,  0, 1, 0, 1, 4'h0, 0,   1,   0,    0,     4'h0, 0, "stop_alone_armed2");
      add(1,  0, 1, 1, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "race_start");
      add(49, 0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "race_count");
      add(1,  0, 1, 0, 1, 4'h3, 0,   1,   1,    50,    4'h3, 0, "stop_beats_timeout");
      add(10, 0, 1, 1, 1, 4'hC, 0,   1,   1,    50,    4'h3, 0, "backpressure");
      add(1,  0, 1, 0, 0, 4'h0, 1,   1,   0,    0,     4'h0, 0, "accept_bp");
      add(5,  0, 1, 0, 0, 4'h0, 1,   1,   0,    0,     4'h0, 0, "no_spurious");
      add(1,  0, 1, 1, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "abort_start");
      add(5,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "abort_count");
      add(1,  0, 0, 0, 1, 4'h8, 0,   0,   0,    0,     4'h0, 0, "abort_disable");
      add(3,  0, 0, 0, 0, 4'h0, 0,   0,   0,    0,     4'h0, 0, "idle_after_abort");
      add(1,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "reenable");
      add(8,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "rewarmup");
      add(1,  0, 1, 1, 1, 4'h9, 0,   1,   1,    0,     4'h9, 0, "hold_before_reset");
      add(1,  1, 1, 0, 0, 4'h0, 0,   0,   0,    0,     4'h0, 0, "reset_in_hold");
      add(1,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "post_reset_enable");
      add(7,  0, 1, 0, 0, 4'h0, 0,   1,   0,    0,     4'h0, 0, "post_reset_warmup");
      add(1,  0, 1, 1, 1, 4'h1, 0,   1,   0,    0,     4'h0, 0, "early_start_ignored");
      add(1,  0, 1, 1, 1, 4'h2, 0,   1,   1,    0,     4'h2, 0, "first_start_ok");
      add(1,  0, 1, 0, 0, 4'h0, 1,   1,   0,    0,     4'h0, 0, "accept_first");
      add(1,  0, 1, 1, 1, 4'h4, 0,   1,   1,    0,     4'h4, 0, "hold_for_disable");
      add(3,  0, 0, 0, 0, 4'h0, 0,   1,   1,    0,     4'h4, 0, "hold_disabled");
      add(1,  0, 0, 0, 0, 4'h0, 1,   0,   0,    0,     4'h0, 0, "accept_to_idle");

      for (int r = 0; r < vecs.size(); r++) begin
         for (int c = 0; c < vecs[r].rep; c++) begin
            reset      = vecs[r].rst;
            enable     = vecs[r].en;
            startPulse = vecs[r].st;
            stopPulse  = vecs[r].sp;
            fineCode   = vecs[r].fc;
            measReady  = vecs[r].rdy;
            step();
         end
         $display("row %0d %s: busy=%0b gate=%0b valid=%0b coarse=%0d fine=%0h to=%0b",
                  r, vecs[r].name, busy, clkGateEn, measValid, coarseCount, fineOut, timeout);
         chk({vecs[r].name, ".busy"},      32'(busy),      32'(vecs[r].eb));
         chk({vecs[r].name, ".clkGateEn"}, 32'(clkGateEn), 32'(vecs[r].eb));
         chk({vecs[r].name, ".measValid"}, 32'(measValid), 32'(vecs[r].ev));
         if (vecs[r].ev || vecs[r].rst) begin
            chk({vecs[r].name, ".coarse"},  coarseCount,   vecs[r].ec);
            chk({vecs[r].name, ".fine"},    32'(fineOut),  32'(vecs[r].ef));
            chk({vecs[r].name, ".timeout"}, 32'(timeout),  32'(vecs[r].et));
         end
      end

      // Warm-up length from IDLE: start+stop held high from the first enabled
      // edge; the result must appear after exactly WARMUP_CYCLES+2 edges.
      reset = 1'b0; enable = 1'b1; startPulse = 1'b1; stopPulse = 1'b1;
      fineCode = 4'h6; measReady = 1'b0;
      k = 0; got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         k++;
         if (measValid) got = 1'b1;
      end
      $display("warmup_seq: edges=%0d valid=%0b coarse=%0d fine=%0h", k, measValid, coarseCount, fineOut);
      chk("warmup_len_edges", 32'(k), 32'(WU + 2));
      chk("warmup_seq.fine", 32'(fineOut), 32'h6);
      chk("warmup_seq.coarse", coarseCount, 32'd0);
      startPulse = 1'b0; stopPulse = 1'b0; measReady = 1'b1;
      step();
      $display("warmup_seq accept: valid=%0b busy=%0b", measValid, busy);
      chk("warmup_seq.accept_valid", 32'(measValid), 32'd0);
      chk("warmup_seq.accept_busy", 32'(busy), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
